// File: rtl/alu_datapath_pkg.sv
// Shared datapath constants: default register width and the select encodings
// for the operand-B and writeback multiplexers.
package alu_datapath_pkg;

  localparam int unsigned REGISTER_DATA_BITS = 8;

  localparam logic ALU_B_IMM = 1'b0;
  localparam logic ALU_B_REG = 1'b1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_RD0 = 2'd3;

endpackage

// File: rtl/alu.sv
// Registered adder/subtractor: captures result, carry and zero flag when enabled.
module alu import alu_datapath_pkg::*; #(
  parameter int unsigned DATA_BITS = REGISTER_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 cin_i,
  input  logic [DATA_BITS-1:0] a_i,
  input  logic [DATA_BITS-1:0] b_i,
  output logic [DATA_BITS-1:0] result_o,
  output logic                 cout_o,
  output logic                 zero_o
);

  logic [DATA_BITS-1:0] b_eff;
  logic [DATA_BITS:0]   sum_full;
  logic [DATA_BITS-1:0] result_d, result_q;
  logic                 cout_d, cout_q;
  logic                 zero_d, zero_q;

  // Subtraction is a + ~b + 1, so carry-out means "no borrow".
  always_comb begin
    b_eff    = cin_i ? ~b_i : b_i;
    sum_full = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_BITS{1'b0}}, cin_i};
  end

  always_comb begin
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    if (en_i) begin
      result_d = sum_full[DATA_BITS-1:0];
      cout_d   = sum_full[DATA_BITS];
      zero_d   = (sum_full[DATA_BITS-1:0] == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign zero_o   = zero_q;

endmodule

// File: rtl/mux2to1.sv
// Two-input data multiplexer used to pick ALU operand B.
module mux2to1 import alu_datapath_pkg::*; #(
  parameter int unsigned DATA_BITS = REGISTER_DATA_BITS
) (
  input  logic                 sel_i,
  input  logic [DATA_BITS-1:0] in0_i,
  input  logic [DATA_BITS-1:0] in1_i,
  output logic [DATA_BITS-1:0] out_o
);

  always_comb begin
    out_o = (sel_i == ALU_B_REG) ? in1_i : in0_i;
  end

endmodule

// File: rtl/mux4to1.sv
// Four-input data multiplexer used to pick register-file write data.
module mux4to1 import alu_datapath_pkg::*; #(
  parameter int unsigned DATA_BITS = REGISTER_DATA_BITS
) (
  input  logic [1:0]           sel_i,
  input  logic [DATA_BITS-1:0] in0_i,
  input  logic [DATA_BITS-1:0] in1_i,
  input  logic [DATA_BITS-1:0] in2_i,
  input  logic [DATA_BITS-1:0] in3_i,
  output logic [DATA_BITS-1:0] out_o
);

  always_comb begin
    out_o = in0_i;
    unique case (sel_i)
      WB_ALU:  out_o = in0_i;
      WB_IMM:  out_o = in1_i;
      WB_MEM:  out_o = in2_i;
      WB_RD0:  out_o = in3_i;
      default: out_o = in0_i;
    endcase
  end

endmodule

// File: rtl/alu_datapath.sv
// Execute-stage datapath: operand-B select, registered ALU and writeback select.
module alu_datapath import alu_datapath_pkg::*; #(
  parameter int unsigned DATA_BITS = REGISTER_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alu_en,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] imm,
  input  logic [DATA_BITS-1:0] rf_b,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 b_sel,
  input  logic                 cin,
  input  logic [1:0]           wb_sel,
  output logic [DATA_BITS-1:0] alu_b,
  output logic [DATA_BITS-1:0] result,
  output logic                 cout,
  output logic                 zero,
  output logic [DATA_BITS-1:0] wb_data
);

  mux2to1 #(.DATA_BITS(DATA_BITS)) u_mux_b (
    .sel_i (b_sel),
    .in0_i (imm),
    .in1_i (rf_b),
    .out_o (alu_b)
  );

  alu #(.DATA_BITS(DATA_BITS)) u_alu (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .en_i     (alu_en),
    .cin_i    (cin),
    .a_i      (a),
    .b_i      (alu_b),
    .result_o (result),
    .cout_o   (cout),
    .zero_o   (zero)
  );

  // Source 0 is the registered result, not the live sum.
  mux4to1 #(.DATA_BITS(DATA_BITS)) u_mux_wb (
    .sel_i (wb_sel),
    .in0_i (result),
    .in1_i (imm),
    .in2_i (load_data),
    .in3_i (a),
    .out_o (wb_data)
  );

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: vector table plus hold, writeback and reset sequences.
module tb_alu_datapath;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n, alu_en, b_sel, cin;
  logic [W-1:0] a, imm, rf_b, load_data;
  logic [1:0]   wb_sel;
  logic [W-1:0] alu_b, result, wb_data;
  logic         cout, zero;

  int n_tests = 0;
  int n_fail  = 0;

  alu_datapath #(.DATA_BITS(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_en    (alu_en),
    .a         (a),
    .imm       (imm),
    .rf_b      (rf_b),
    .load_data (load_data),
    .b_sel     (b_sel),
    .cin       (cin),
    .wb_sel    (wb_sel),
    .alu_b     (alu_b),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, imm, rf_b;
    logic         b_sel, cin;
    logic [W-1:0] exp_alu_b, exp_result;
    logic         exp_cout, exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [W-1:0] r, input logic c,
                            input logic z);
    check({tag, ".result"}, 32'(result), 32'(r));
    check({tag, ".cout"}, 32'(cout), 32'(c));
    check({tag, ".zero"}, 32'(zero), 32'(z));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            a      imm    rf_b   bsel  cin   alu_b  result cout  zero
    vecs[0] = '{8'h7F, 8'h01, 8'hAA, 1'b0, 1'b0, 8'h01, 8'h80, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h55, 8'h01, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'h05, 8'h33, 8'h05, 1'b1, 1'b1, 8'h05, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h03, 8'h44, 8'h05, 1'b1, 1'b1, 8'h05, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 8'h99, 1'b0, 1'b1, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 8'h01, 1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 8'h77, 8'h00, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 8'h66, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};

    // Reset held with a pending capture that would produce a nonzero result.
    reset_n = 1'b0; alu_en = 1'b1; a = 8'h7F; imm = 8'h01; rf_b = 8'h00;
    load_data = 8'h00; b_sel = 1'b0; cin = 1'b0; wb_sel = 2'd0;
    tick(); tick();
    check_regs("reset", 8'h00, 1'b0, 1'b0);
    check("reset.wb_data", 32'(wb_data), 32'h00);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = vecs[i].a; imm = vecs[i].imm; rf_b = vecs[i].rf_b;
      b_sel = vecs[i].b_sel; cin = vecs[i].cin; alu_en = 1'b1; wb_sel = 2'd0;
      #1;
      check($sformatf("vec%0d.alu_b", i), 32'(alu_b), 32'(vecs[i].exp_alu_b));
      tick();
      check_regs($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_cout,
                 vecs[i].exp_zero);
      check($sformatf("vec%0d.wb_data", i), 32'(wb_data), 32'(vecs[i].exp_result));
    end

    // Hold: capture 0x80, then three disabled cycles with changing inputs.
    @(negedge clk);
    a = 8'h7F; imm = 8'h01; b_sel = 1'b0; cin = 1'b0; alu_en = 1'b1;
    tick();
    check_regs("hold.cap", 8'h80, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      alu_en = 1'b0; a = 8'(8'hF0 + k); rf_b = 8'h10; b_sel = 1'b1; cin = k[0];
      tick();
      check_regs($sformatf("hold%0d", k), 8'h80, 1'b0, 1'b0);
    end

    // Writeback mux, evaluated without any clock edge.
    @(negedge clk);
    imm = 8'h11; load_data = 8'h22; a = 8'h33;
    for (int s = 0; s < 4; s++) begin
      wb_sel = 2'(s);
      #1;
      case (s)
        0: check("wb.alu", 32'(wb_data), 32'h80);
        1: check("wb.imm", 32'(wb_data), 32'h11);
        2: check("wb.mem", 32'(wb_data), 32'h22);
        default: check("wb.rd0", 32'(wb_data), 32'h33);
      endcase
    end

    // Reset priority over a pending capture.
    @(negedge clk);
    a = 8'h03; rf_b = 8'h05; b_sel = 1'b1; cin = 1'b1; alu_en = 1'b1; wb_sel = 2'd0;
    tick();
    check_regs("rst.cap", 8'hFE, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'hFF; rf_b = 8'h01; b_sel = 1'b1; cin = 1'b0; reset_n = 1'b0; alu_en = 1'b1;
    tick();
    check_regs("rst.prio", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1; alu_en = 1'b0;
    tick();
    check_regs("rst.after", 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
